// File: rtl/tc_reg_arb_pkg.sv
// Shared types and timing constants for the register bank arbiter.
package tc_reg_arb_pkg;

   // Transaction sequencer states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_LOAD = 3'd2,
      RD_CAPT = 3'd3,
      RESP    = 3'd4
   } arb_state_t;

   // Edges from the request-sampling edge to the edge where done is observed
   localparam int WR_LATENCY = 2;
   localparam int RD_LATENCY = 3;

endpackage

// File: rtl/tc_register_bank_arbiter_rr.sv
// Combinational round-robin picker: scans upward from ptr, wrapping at N,
// and reports the first set request as a one-hot vector and an index.
module tc_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     winner,
   output logic [IDX_W-1:0] winner_idx,
   output logic             any_req
);

   // Priority scan starting at ptr; the first hit blocks all later ones
   always_comb begin
      int   pos_s;
      logic hit_s;
      winner     = {N{1'b0}};
      winner_idx = {IDX_W{1'b0}};
      any_req    = 1'b0;
      pos_s      = 0;
      hit_s      = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos_s       = ((int'(ptr) + k) >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
         hit_s       = req[pos_s] & ~any_req;
         winner[pos_s] = hit_s;
         winner_idx  = hit_s ? IDX_W'(pos_s) : winner_idx;
         any_req     = any_req | req[pos_s];
      end
   end

endmodule

// File: rtl/tc_register_bank_arbiter.sv
// Round-robin arbiter sharing a bank of single-port registers between
// several requesters. Sequences save/load enables to the bank timing
// (save on falling edge, read data one rising edge after load).
module tc_register_bank_arbiter
   import tc_reg_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter int SIZE     = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*SIZE-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [SIZE-1:0]           rdata,
   output logic                      busy,
   output logic [NUM_REGS-1:0]       reg_load,
   output logic [NUM_REGS-1:0]       reg_save,
   output logic [SIZE-1:0]           reg_in,
   input  logic [SIZE-1:0]           reg_out
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t          state_r, state_next_s;
   logic [IDX_W-1:0]    ptr_r, ptr_next_s;
   logic                write_r, write_next_s;
   logic [ADDR_W-1:0]   addr_r, addr_next_s;
   logic [SIZE-1:0]     wdata_r, wdata_next_s;

   logic [NUM_REQ-1:0]  win_onehot_s;
   logic [IDX_W-1:0]    win_idx_s;
   logic                any_req_s;

   logic                addr_ok_s;
   logic [NUM_REGS-1:0] addr_onehot_s;
   logic [NUM_REQ-1:0]  gnt_next_s, done_next_s;
   logic [SIZE-1:0]     rdata_next_s, reg_in_next_s;
   logic                busy_next_s;
   logic [NUM_REGS-1:0] reg_load_next_s, reg_save_next_s;

   tc_rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req        (req),
      .ptr        (ptr_r),
      .winner     (win_onehot_s),
      .winner_idx (win_idx_s),
      .any_req    (any_req_s)
   );

   // State register plus the latched transaction (inputs are only sampled in IDLE)
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= IDLE;
         ptr_r   <= {IDX_W{1'b0}};
         write_r <= 1'b0;
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= {SIZE{1'b0}};
      end else begin
         state_r <= state_next_s;
         ptr_r   <= ptr_next_s;
         write_r <= write_next_s;
         addr_r  <= addr_next_s;
         wdata_r <= wdata_next_s;
      end
   end

   // Next-state logic; accepting a request latches it and rotates priority past the winner
   always_comb begin
      state_next_s = state_r;
      ptr_next_s   = ptr_r;
      write_next_s = write_r;
      addr_next_s  = addr_r;
      wdata_next_s = wdata_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               write_next_s = req_write[win_idx_s];
               addr_next_s  = req_addr[win_idx_s*ADDR_W +: ADDR_W];
               wdata_next_s = req_wdata[win_idx_s*SIZE +: SIZE];
               ptr_next_s   = (win_idx_s == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}}
                                                                 : (win_idx_s + IDX_W'(1));
               state_next_s = req_write[win_idx_s] ? WR : RD_LOAD;
            end else begin
               state_next_s = IDLE;
            end
         end
         WR:      state_next_s = RESP;
         RD_LOAD: state_next_s = RD_CAPT;
         RD_CAPT: state_next_s = RESP;
         RESP:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output comes straight from a flop
   always_comb begin
      addr_ok_s     = (int'(addr_next_s) < NUM_REGS);
      addr_onehot_s = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr_next_s;

      if (state_r == IDLE && any_req_s) begin
         gnt_next_s = win_onehot_s;
      end else if (state_next_s == IDLE) begin
         gnt_next_s = {NUM_REQ{1'b0}};
      end else begin
         gnt_next_s = gnt;
      end

      if (state_next_s == RESP) begin
         done_next_s = gnt;
      end else begin
         done_next_s = {NUM_REQ{1'b0}};
      end

      // Out-of-range addresses still sequence normally but never raise an enable
      if (state_next_s == WR && addr_ok_s) begin
         reg_save_next_s = addr_onehot_s;
      end else begin
         reg_save_next_s = {NUM_REGS{1'b0}};
      end

      if (state_next_s == WR) begin
         reg_in_next_s = wdata_next_s;
      end else begin
         reg_in_next_s = {SIZE{1'b0}};
      end

      if (state_next_s == RD_LOAD && addr_ok_s) begin
         reg_load_next_s = addr_onehot_s;
      end else begin
         reg_load_next_s = {NUM_REGS{1'b0}};
      end

      // The bank drives reg_out during RD_CAPT (pulled to 0 if nothing was loaded)
      if (state_r == RD_CAPT) begin
         rdata_next_s = reg_out;
      end else begin
         rdata_next_s = rdata;
      end

      busy_next_s = (state_next_s != IDLE);
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         gnt      <= {NUM_REQ{1'b0}};
         done     <= {NUM_REQ{1'b0}};
         rdata    <= {SIZE{1'b0}};
         busy     <= 1'b0;
         reg_load <= {NUM_REGS{1'b0}};
         reg_save <= {NUM_REGS{1'b0}};
         reg_in   <= {SIZE{1'b0}};
      end else begin
         gnt      <= gnt_next_s;
         done     <= done_next_s;
         rdata    <= rdata_next_s;
         busy     <= busy_next_s;
         reg_load <= reg_load_next_s;
         reg_save <= reg_save_next_s;
         reg_in   <= reg_in_next_s;
      end
   end

endmodule

// File: doc/tc_register_bank_arbiter.md
Name: tc_register_bank_arbiter

Overview:
- Shares a bank of NUM_REGS single-port registers between NUM_REQ requesters. The registers have these properties:
  - one load and one save enable each;
  - save is captured on the clock falling edge;
  - read data is driven onto a pull-down (tri0) bus one rising edge after load.
- The block picks one requester per transaction using round-robin arbitration, then sequences the save/load enables to match the register timing.
- It returns read data and a completion pulse to the winning requester.
- It sits between CPU-style masters (ALU, I/O, program counter) and the shared register bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_REGS, 8, number of registers in the bank.
- ADDR_W, 3, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- SIZE, 8, register data width.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  per-requester request, level; held until done.
- req_write  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*SIZE  packed write data.
- gnt  output  NUM_REQ  one-hot grant, registered.
- done  output  NUM_REQ  one-cycle completion pulse, registered.
- rdata  output  SIZE  read result; valid in the done cycle and held until the next read completes.
- busy  output  1  high in any state other than IDLE.
- reg_load  output  NUM_REGS  load enables to the bank.
- reg_save  output  NUM_REGS  save enables to the bank.
- reg_in  output  SIZE  write data to all registers.
- reg_out  input  SIZE  shared bank output bus; reads 0 when no register drives it.

Behaviour:
- Reset (rst == 0 at a rising edge) forces the following, regardless of the current state:
  - state = IDLE;
  - gnt, done, reg_load, reg_save, reg_in, rdata all 0; busy = 0;
  - round-robin pointer = 0, so requester 0 has highest priority.
- Reset in the middle of a transaction abandons it. No done is issued.
- States: IDLE, WR, RD_LOAD, RD_CAPT, RESP.
- IDLE:
  - If no req is set, stay in IDLE.
  - Otherwise pick the first set req scanning upward from the pointer, wrapping modulo NUM_REQ.
  - Latch the winner's index, write flag, address and write data.
  - Set gnt[idx] = 1.
  - Advance the pointer to idx+1 (mod NUM_REQ).
  - Go to WR if writing, else RD_LOAD.
- WR:
  - reg_save[addr] = 1 and reg_in = latched wdata for exactly this cycle.
  - The register captures on the falling edge within WR.
  - Next state: RESP.
- RD_LOAD:
  - reg_load[addr] = 1 for exactly this cycle; the register drives reg_out from the next rising edge.
  - Next state: RD_CAPT.
- RD_CAPT:
  - reg_load = 0; reg_out is valid throughout this cycle.
  - rdata <= reg_out at the rising edge that ends RD_CAPT.
  - Next state: RESP.
- RESP:
  - done[idx] = 1 for one cycle; gnt cleared at the end of RESP.
  - Next state: IDLE.
- Latency from the req-sampled edge to the done cycle: 2 cycles for a write, 3 cycles for a read.
- Back-to-back transactions: one idle cycle between done and the next grant.
- A requester must drop req in the done cycle. If req is still high in the following IDLE cycle, it counts as a new request at the rotated priority.
- Inputs are sampled only in IDLE. Changes to addr/wdata/write while granted are ignored.
- Out-of-range address (addr >= NUM_REGS):
  - no reg_load or reg_save bit is asserted;
  - a read returns 0, because the bus is pulled down;
  - done is still pulsed.
- Enable invariants:
  - at most one bit of reg_load | reg_save is high in any cycle;
  - reg_load and reg_save are never both high;
  - reg_in is 0 outside WR.
- The block never drives register reset. Clearing the bank is outside this block.

Decomposition:
- Shared package tc_reg_arb_pkg, containing:
  - the state enum (IDLE, WR, RD_LOAD, RD_CAPT, RESP);
  - localparams for write and read latency.
- One sub-module: tc_rr_arbiter.
  - Combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner, winner index, any_req.
  - Reusable by other shared-resource controllers.

Test Plan:
- Reset priority: rst low 2 cycles then high; req=0001, write, addr 3, wdata 0xA5 -> gnt=0001 next cycle; reg_save=0000_1000 and reg_in=0xA5 for exactly one cycle; done[0] two cycles after sample; busy low afterwards.
- Read latency: bank register 3 models 0xA5; req[2] read addr 3 -> reg_load[3] for one cycle; rdata=0xA5 with done[2] three cycles after sample; rdata holds 0xA5 in later idle cycles.
- Round-robin: req=1111 held, all reads, each requester drops req on its done -> grant order 0,1,2,3. Then req=1001 -> order 0,3 after pointer returns to 0; requester 3 is served first if the pointer is at 1.
- Out-of-range: NUM_REGS=6, read addr 7 -> no reg_load bit set; rdata=0x00; done pulses. Write addr 6 -> reg_save stays 0; done pulses.
- Reset mid-read: assert rst in RD_LOAD -> next cycle reg_load=0, gnt=0, busy=0, no done; rdata=0; a following req[1] is granted ahead of req[3].
- Invariant check: over 1000 random transactions, a scoreboard compares against a reference memory, and assertions confirm onehot0(reg_load|reg_save) and onehot0(gnt) in every cycle.
